// File: rtl/flux_fetch_pkg.sv
// Shared types and constants for the shader fetch sequencer.
package flux_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_REQ,
    ST_FETCH_WAIT,
    ST_ISSUE,
    ST_DONE
  } fetch_state_e;

  // Byte distance between consecutive instructions
  localparam int PC_STEP = 4;

  // Instruction word the core decodes as halt
  localparam logic [31:0] HALT_OPCODE = 32'h0000_0073;

endpackage

// File: rtl/next_active_thread.sv
// Finds the next active thread in a mask, either at or strictly above the current id.
module next_active_thread #(
  parameter int NUM_THREADS = 32,
  parameter int TID_W       = $clog2(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0] mask,
  input  logic [TID_W-1:0]       current_id,
  input  logic                   include_current,
  output logic [TID_W-1:0]       next_id,
  output logic                   is_last
);

  // Scan from the top down so the lowest qualifying bit wins; is_last means nothing is set above current_id
  always_comb begin
    next_id = '0;
    is_last = 1'b1;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(current_id)) || (include_current && (i == int'(current_id))))) begin
        next_id = TID_W'(i);
      end
      if (mask[i] && (i > int'(current_id))) begin
        is_last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/shader_fetch_sequencer.sv
// Fetches one instruction per PC and replays it once per active thread to the shader core.
module shader_fetch_sequencer #(
  parameter int NUM_THREADS = 32,
  parameter int PC_WIDTH    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [PC_WIDTH-1:0]        start_pc,
  input  logic [NUM_THREADS-1:0]     thread_mask,
  output logic                       imem_req_valid,
  output logic [PC_WIDTH-1:0]        imem_req_addr,
  input  logic                       imem_req_ready,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_data,
  output logic                       core_enable,
  output logic [31:0]                core_instruction,
  output logic [$clog2(NUM_THREADS)-1:0] core_thread_id,
  input  logic                       core_halted,
  output logic [PC_WIDTH-1:0]        pc,
  output logic                       busy,
  output logic                       done
);

  import flux_fetch_pkg::*;

  localparam int TID_W = $clog2(NUM_THREADS);

  fetch_state_e           state;
  fetch_state_e           next_state;
  logic [NUM_THREADS-1:0] mask_q;
  logic                   issue_first;
  logic                   halt_on_entry;
  logic                   nat_include;
  logic [TID_W-1:0]       nat_current;
  logic [TID_W-1:0]       nat_next;
  logic                   nat_is_last;

  // While waiting for the fetch we look for the lowest active thread; while issuing, the one after the current
  assign nat_include = (state == ST_FETCH_WAIT);
  assign nat_current = nat_include ? '0 : core_thread_id;

  next_active_thread #(
    .NUM_THREADS (NUM_THREADS),
    .TID_W       (TID_W)
  ) u_next_thread (
    .mask            (mask_q),
    .current_id      (nat_current),
    .include_current (nat_include),
    .next_id         (nat_next),
    .is_last         (nat_is_last)
  );

  // A halt is only honoured on the first cycle of an instruction, before any thread has been issued
  assign halt_on_entry = issue_first && core_halted;
  assign imem_req_addr = pc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    next_state     = state;
    imem_req_valid = 1'b0;
    core_enable    = 1'b0;
    busy           = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = (thread_mask == '0) ? ST_DONE : ST_FETCH_REQ;
        end
      end
      ST_FETCH_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          next_state = ST_FETCH_WAIT;
        end
      end
      ST_FETCH_WAIT: begin
        if (imem_rsp_valid) begin
          next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (halt_on_entry) begin
          next_state = ST_DONE;
        end else begin
          core_enable = 1'b1;
          if (nat_is_last) begin
            next_state = ST_FETCH_REQ;
          end
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Completion pulse lands on the cycle the machine is back in IDLE, so busy and done never overlap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else begin
      done <= (state == ST_DONE);
    end
  end

  // Marks the first ISSUE cycle of each fetched instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_first <= 1'b0;
    end else begin
      issue_first <= (state == ST_FETCH_WAIT) && imem_rsp_valid;
    end
  end

  // Launch parameters are captured only when a start is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if ((state == ST_IDLE) && start) begin
      mask_q <= thread_mask;
    end
  end

  // Program counter: loaded on start, stepped after the last active thread has issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if ((state == ST_IDLE) && start) begin
      pc <= start_pc;
    end else if (core_enable && nat_is_last) begin
      pc <= pc + PC_WIDTH'(PC_STEP);
    end
  end

  // Instruction register and issued thread id; both hold their value outside ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_instruction <= '0;
      core_thread_id   <= '0;
    end else if ((state == ST_FETCH_WAIT) && imem_rsp_valid) begin
      core_instruction <= imem_rsp_data;
      core_thread_id   <= nat_next;
    end else if (core_enable && !nat_is_last) begin
      core_thread_id   <= nat_next;
    end
  end

endmodule

// File: tb/tb_shader_fetch_sequencer.sv
// Directed self-checking bench for shader_fetch_sequencer.
module tb_shader_fetch_sequencer;

  import flux_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_pc = '0;
  logic [31:0] thread_mask = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        core_enable;
  logic [31:0] core_instruction;
  logic [4:0]  core_thread_id;
  logic        core_halted;
  logic [31:0] pc;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  int accept_count = 0;
  int enable_count = 0;
  int done_count = 0;

  // Core-side halt decode
  assign core_halted = (core_instruction == HALT_OPCODE);

  shader_fetch_sequencer #(
    .NUM_THREADS (32),
    .PC_WIDTH    (32)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .start_pc         (start_pc),
    .thread_mask      (thread_mask),
    .imem_req_valid   (imem_req_valid),
    .imem_req_addr    (imem_req_addr),
    .imem_req_ready   (imem_req_ready),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .core_enable      (core_enable),
    .core_instruction (core_instruction),
    .core_thread_id   (core_thread_id),
    .core_halted      (core_halted),
    .pc               (pc),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  // Event counters sampled on the active edge
  always @(posedge clk) begin
    if (imem_req_valid && imem_req_ready) accept_count++;
    if (core_enable) enable_count++;
    if (done) done_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    accept_count = 0;
    enable_count = 0;
    done_count = 0;
  endtask

  task automatic launch(input logic [31:0] addr, input logic [31:0] mask);
    start = 1'b1;
    start_pc = addr;
    thread_mask = mask;
    tick();
    start = 1'b0;
  endtask

  task automatic serve_fetch(input logic [31:0] data);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = data;
    tick();
    imem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({imem_req_valid, core_enable, busy, done} !== 4'b0000 || pc !== 32'h0 ||
        core_instruction !== 32'h0 || core_thread_id !== 5'd0) begin
      failures++;
      $display("[TB] FAIL reset_state: req=%b en=%b busy=%b done=%b pc=%h instr=%h id=%0d, need all zero",
               imem_req_valid, core_enable, busy, done, pc, core_instruction, core_thread_id);
    end
  endtask

  task automatic test_full_mask();
    do_reset();
    launch(32'h100, 32'hFFFF_FFFF);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full_first_req: valid=%b addr=%h busy=%b, need 1 00000100 1", imem_req_valid, imem_req_addr, busy);
    end
    serve_fetch(32'h0000_0013);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (core_enable !== 1'b1 || core_thread_id !== 5'(i) || core_instruction !== 32'h13) begin
        failures++;
        $display("[TB] FAIL full_issue_%0d: en=%b id=%0d instr=%h, need 1 %0d 00000013", i, core_enable, core_thread_id, core_instruction, i);
      end
      tick();
    end
    checks++;
    if (core_enable !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h104 || pc !== 32'h104) begin
      failures++;
      $display("[TB] FAIL full_next_req: en=%b valid=%b addr=%h pc=%h, need 0 1 00000104 00000104", core_enable, imem_req_valid, imem_req_addr, pc);
    end
  endtask

  task automatic test_sparse_mask();
    logic [4:0] ids [3];
    ids[0] = 5'd0;
    ids[1] = 5'd2;
    ids[2] = 5'd31;
    do_reset();
    launch(32'h200, 32'h8000_0005);
    serve_fetch(32'h0000_0013);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (core_enable !== 1'b1 || core_thread_id !== ids[i]) begin
        failures++;
        $display("[TB] FAIL sparse_issue_%0d: en=%b id=%0d, need 1 %0d", i, core_enable, core_thread_id, ids[i]);
      end
      tick();
    end
    checks++;
    if (core_enable !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h204 || enable_count != 3) begin
      failures++;
      $display("[TB] FAIL sparse_after: en=%b valid=%b addr=%h enables=%0d, need 0 1 00000204 3", core_enable, imem_req_valid, imem_req_addr, enable_count);
    end
  endtask

  task automatic test_stall();
    do_reset();
    launch(32'h300, 32'h0000_0003);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin
        failures++;
        $display("[TB] FAIL stall_req_%0d: valid=%b addr=%h, need 1 00000300", i, imem_req_valid, imem_req_addr);
      end
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (core_enable !== 1'b0 || imem_req_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stall_wait_%0d: en=%b valid=%b, need 0 0", i, core_enable, imem_req_valid);
      end
      tick();
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0000_0013;
    tick();
    imem_rsp_valid = 1'b0;
    checks++;
    if (core_enable !== 1'b1 || core_thread_id !== 5'd0) begin
      failures++;
      $display("[TB] FAIL stall_issue0: en=%b id=%0d, need 1 0", core_enable, core_thread_id);
    end
    tick();
    checks++;
    if (core_enable !== 1'b1 || core_thread_id !== 5'd1) begin
      failures++;
      $display("[TB] FAIL stall_issue1: en=%b id=%0d, need 1 1", core_enable, core_thread_id);
    end
    tick();
    checks++;
    if (accept_count != 1 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h304) begin
      failures++;
      $display("[TB] FAIL stall_accepts: accepts=%0d valid=%b addr=%h, need 1 1 00000304", accept_count, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_halt();
    do_reset();
    launch(32'h400, 32'h0000_0003);
    serve_fetch(32'h0000_0013);
    tick();
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h404) begin
      failures++;
      $display("[TB] FAIL halt_second_req: valid=%b addr=%h, need 1 00000404", imem_req_valid, imem_req_addr);
    end
    serve_fetch(HALT_OPCODE);
    checks++;
    if (core_enable !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL halt_entry: en=%b busy=%b, need 0 1", core_enable, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || core_enable !== 1'b0) begin
      failures++;
      $display("[TB] FAIL halt_done_state: done=%b busy=%b en=%b, need 0 1 0", done, busy, core_enable);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pc !== 32'h404) begin
      failures++;
      $display("[TB] FAIL halt_done_pulse: done=%b busy=%b pc=%h, need 1 0 00000404", done, busy, pc);
    end
    tick();
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || done_count != 1 || enable_count != 2) begin
      failures++;
      $display("[TB] FAIL halt_after: done=%b busy=%b pulses=%0d enables=%0d, need 0 0 1 2", done, busy, done_count, enable_count);
    end
  endtask

  task automatic test_zero_mask();
    do_reset();
    launch(32'h500, 32'h0);
    checks++;
    if (imem_req_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL zero_cycle1: valid=%b done=%b busy=%b, need 0 0 1", imem_req_valid, done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || accept_count != 0) begin
      failures++;
      $display("[TB] FAIL zero_cycle2: done=%b busy=%b accepts=%0d, need 1 0 0", done, busy, accept_count);
    end
    tick();
    launch(32'h600, 32'h0000_0001);
    start = 1'b1;
    start_pc = 32'h900;
    thread_mask = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    checks++;
    if (imem_req_addr !== 32'h600 || pc !== 32'h600) begin
      failures++;
      $display("[TB] FAIL busy_start_ignored: addr=%h pc=%h, need 00000600 00000600", imem_req_addr, pc);
    end
    serve_fetch(32'h0000_0013);
    checks++;
    if (core_enable !== 1'b1 || core_thread_id !== 5'd0) begin
      failures++;
      $display("[TB] FAIL busy_mask_kept_issue: en=%b id=%0d, need 1 0", core_enable, core_thread_id);
    end
    tick();
    checks++;
    if (core_enable !== 1'b0 || imem_req_addr !== 32'h604) begin
      failures++;
      $display("[TB] FAIL busy_mask_kept_next: en=%b addr=%h, need 0 00000604", core_enable, imem_req_addr);
    end
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    launch(32'h700, 32'h0000_000F);
    serve_fetch(32'h0000_0013);
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req_valid, core_enable, busy, done} !== 4'b0000 || pc !== 32'h0 ||
        core_instruction !== 32'h0 || core_thread_id !== 5'd0) begin
      failures++;
      $display("[TB] FAIL midreset_state: req=%b en=%b busy=%b done=%b pc=%h instr=%h id=%0d, need all zero",
               imem_req_valid, core_enable, busy, done, pc, core_instruction, core_thread_id);
    end
    tick();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    tick();
    checks++;
    if (core_instruction !== 32'h0 || busy !== 1'b0 || core_enable !== 1'b0) begin
      failures++;
      $display("[TB] FAIL late_rsp_ignored: instr=%h busy=%b en=%b, need 00000000 0 0", core_instruction, busy, core_enable);
    end
    launch(32'hFFFF_FFFC, 32'h0000_0001);
    serve_fetch(32'h0000_0013);
    tick();
    checks++;
    if (pc !== 32'h0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL pc_wrap: pc=%h valid=%b addr=%h, need 00000000 1 00000000", pc, imem_req_valid, imem_req_addr);
    end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_stall();
    test_halt();
    test_zero_mask();
    test_reset_mid_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
